ack_bus_requester: RTL and testbench

//  Module-side transmitter for the open-drain ACK bus; one instance per source (MEM/SHA/AES/CTRL).

---
 rtl/ack_bus_pkg.sv | 27 ++
 rtl/ack_bus_requester_if.sv | 34 +++
 rtl/ack_bus_requester.sv | 149 ++++++++++++++
 tb/tb_ack_bus_requester.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ack_bus_pkg.sv
// Shared definitions for the open-drain ACK bus: source IDs, the released
// ID pattern, the requester FSM state encoding and the backoff length rule.
package ack_bus_pkg;

  localparam logic [1:0] SRC_MEM  = 2'b00;
  localparam logic [1:0] SRC_SHA  = 2'b01;
  localparam logic [1:0] SRC_AES  = 2'b10;
  localparam logic [1:0] SRC_CTRL = 2'b11;

  // All-ones ID means every open-drain ID bit is released.
  localparam logic [1:0] ACK_ID_IDLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SENSE   = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_RELEASE = 3'd4
  } ack_state_e;

  // Lower IDs back off for less time, so after a collision the lower ID
  // retries first and the others find the bus busy when they sense it.
  function automatic int unsigned backoffCycles(input logic [1:0] srcId);
    return 2 * (32'(srcId) + 32'd1);
  endfunction

endpackage

// File: rtl/ack_bus_requester_if.sv
// Handshake bundle between one requester and the resolved ACK bus plus its
// arbiter. The *_drv signals are open-drain drive values (1 = released); the
// *_bus signals are the wired-AND result seen by every source.
interface ack_bus_requester_if;
  import ack_bus_pkg::*;

  logic       ack_valid_n_drv;
  logic [1:0] ack_id_drv;
  logic       req;
  logic       ack_valid_n_bus;
  logic [1:0] ack_id_bus;
  logic       ack_ready;

  // Requester side: drives the bus and the sideband request.
  modport master (
    output ack_valid_n_drv,
    output ack_id_drv,
    output req,
    input  ack_valid_n_bus,
    input  ack_id_bus,
    input  ack_ready
  );

  // Bus/arbiter side: sees the drives, returns the resolved bus and grant.
  modport slave (
    input  ack_valid_n_drv,
    input  ack_id_drv,
    input  req,
    output ack_valid_n_bus,
    output ack_id_bus,
    output ack_ready
  );

endinterface

// File: rtl/ack_bus_requester.sv
// Per-source transmitter for the open-drain ACK bus. Counts owed acks,
// carrier-senses the bus, drives valid/ID low until the arbiter grants,
// backs off on collision or timeout, and leaves a one-cycle released gap
// after every successful ack. All outputs come straight from flops.
module ack_bus_requester
  import ack_bus_pkg::*;
#(
  parameter logic [1:0] SRC_ID  = SRC_SHA,
  parameter int         PEND_W  = 2,
  parameter int         TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ack_bus_requester_if.master  bus,
  input  logic                 done_pulse,
  output logic [PEND_W-1:0]    pending,
  output logic                 busy,
  output logic                 overflow,
  output logic                 timeout_err
);

  localparam logic [PEND_W-1:0] PEND_MAX     = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE     = PEND_W'(1);
  localparam int unsigned       BACKOFF_LEN  = backoffCycles(SRC_ID);
  localparam logic [2:0]        BACKOFF_LAST = 3'(BACKOFF_LEN - 1);
  localparam logic [7:0]        WAIT_LAST    = 8'(TIMEOUT - 1);

  ack_state_e        state_q;
  logic              validN_q;
  logic [1:0]        idDrv_q;
  logic              req_q;
  logic              busy_q;
  logic              timeoutErr_q;
  logic [7:0]        waitCnt_q;
  logic [2:0]        backoffCnt_q;
  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              grant;
  logic              collision;

  // Grant only counts while we are actually on the bus with our own ID.
  assign grant     = (state_q == ST_DRIVE) && bus.ack_ready && (bus.ack_id_bus == SRC_ID);
  assign collision = !bus.ack_valid_n_bus && (bus.ack_id_bus != SRC_ID);

  // Owed-ack counter: saturating, a simultaneous new ack and grant cancel out.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (done_pulse && !grant) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (!done_pulse && grant) begin
      pending_d = pending_q - PEND_ONE;
    end
  end

  // Register the counter and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Bus FSM with registered drive, request and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      validN_q     <= 1'b1;
      idDrv_q      <= ACK_ID_IDLE;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      waitCnt_q    <= '0;
      backoffCnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q != '0) begin
            state_q <= ST_SENSE;
            busy_q  <= 1'b1;
          end
        end
        ST_SENSE: begin
          if (bus.ack_valid_n_bus) begin
            state_q   <= ST_DRIVE;
            validN_q  <= 1'b0;
            idDrv_q   <= SRC_ID;
            req_q     <= 1'b1;
            waitCnt_q <= '0;
          end
        end
        ST_DRIVE: begin
          waitCnt_q <= waitCnt_q + 8'd1;
          if (grant) begin
            state_q  <= ST_RELEASE;
            validN_q <= 1'b1;
            idDrv_q  <= ACK_ID_IDLE;
            req_q    <= 1'b0;
          end else if (collision || (waitCnt_q == WAIT_LAST)) begin
            state_q      <= ST_BACKOFF;
            validN_q     <= 1'b1;
            idDrv_q      <= ACK_ID_IDLE;
            req_q        <= 1'b0;
            backoffCnt_q <= '0;
            if (!collision) begin
              timeoutErr_q <= 1'b1;
            end
          end
        end
        ST_BACKOFF: begin
          if (backoffCnt_q == BACKOFF_LAST) begin
            state_q <= ST_SENSE;
          end else begin
            backoffCnt_q <= backoffCnt_q + 3'd1;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          validN_q <= 1'b1;
          idDrv_q  <= ACK_ID_IDLE;
          req_q    <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_valid_n_drv = validN_q;
  assign bus.ack_id_drv      = idDrv_q;
  assign bus.req             = req_q;
  assign pending             = pending_q;
  assign busy                = busy_q;
  assign overflow            = overflow_q;
  assign timeout_err         = timeoutErr_q;

endmodule

// File: tb/tb_ack_bus_requester.sv
// Bench for ack_bus_requester: an SHA and an AES requester share a
// wired-AND ACK bus; the bench plays the arbiter and keeps a queue of the
// source IDs it expects to grant, in order.
module tb_ack_bus_requester;
  import ack_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       doneSha, doneAes;
  logic       shaReady, aesReady;
  logic [1:0] pendSha, pendAes;
  logic       busySha, busyAes, ovfSha, ovfAes, toSha, toAes;
  logic       busValidN;
  logic [1:0] busId;
  logic [1:0] expQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         found;

  ack_bus_requester_if shaIf();
  ack_bus_requester_if aesIf();

  // Open-drain resolution: any source pulling low wins.
  assign busValidN = shaIf.ack_valid_n_drv & aesIf.ack_valid_n_drv;
  assign busId     = shaIf.ack_id_drv & aesIf.ack_id_drv;
  assign shaIf.ack_valid_n_bus = busValidN;
  assign shaIf.ack_id_bus      = busId;
  assign shaIf.ack_ready       = shaReady;
  assign aesIf.ack_valid_n_bus = busValidN;
  assign aesIf.ack_id_bus      = busId;
  assign aesIf.ack_ready       = aesReady;

  ack_bus_requester #(.SRC_ID(SRC_SHA), .PEND_W(2), .TIMEOUT(15)) dutSha (
    .clk(clk), .rst_n(rst_n), .bus(shaIf), .done_pulse(doneSha),
    .pending(pendSha), .busy(busySha), .overflow(ovfSha), .timeout_err(toSha)
  );

  ack_bus_requester #(.SRC_ID(SRC_AES), .PEND_W(2), .TIMEOUT(15)) dutAes (
    .clk(clk), .rst_n(rst_n), .bus(aesIf), .done_pulse(doneAes),
    .pending(pendAes), .busy(busyAes), .overflow(ovfAes), .timeout_err(toAes)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something above never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle done pulse(s); owed acks that should later be granted are queued.
  task automatic applyStimulus(input logic sha, input logic aes, input bit expectGrant);
    doneSha = sha;
    doneAes = aes;
    if (expectGrant && sha) expQ.push_back(SRC_SHA);
    if (expectGrant && aes) expQ.push_back(SRC_AES);
    tick();
    doneSha = 1'b0;
    doneAes = 1'b0;
  endtask

  // Grant the source on the bus for one cycle and score the ID it shows.
  task automatic grantNow(input logic [1:0] id);
    if (id == SRC_SHA) shaReady = 1'b1;
    else aesReady = 1'b1;
    checkOutput("bus valid at grant", 8'(busValidN), 8'd0);
    checkOutput("scoreboard occupancy", 8'(expQ.size() != 0), 8'd1);
    if (expQ.size() != 0) checkOutput("granted id", 8'(busId), 8'(expQ.pop_front()));
    tick();
    shaReady = 1'b0;
    aesReady = 1'b0;
  endtask

  task automatic waitDrive(input logic [1:0] id, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busValidN == 1'b0 && busId == id) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic waitAndGrant(input logic [1:0] id, input int budget);
    bit seen;
    waitDrive(id, budget, seen);
    checkOutput("drive seen before budget", 8'(seen), 8'd1);
    if (seen) grantNow(id);
  endtask

  initial begin
    rst_n = 1'b0; doneSha = 1'b0; doneAes = 1'b0; shaReady = 1'b0; aesReady = 1'b0;
    tick(); tick();

    // Reset state.
    checkOutput("reset valid_n", 8'(shaIf.ack_valid_n_drv), 8'd1);
    checkOutput("reset id", 8'(shaIf.ack_id_drv), 8'(ACK_ID_IDLE));
    checkOutput("reset req", 8'(shaIf.req), 8'd0);
    checkOutput("reset pending", 8'(pendSha), 8'd0);
    checkOutput("reset flags", 8'({busySha, ovfSha, toSha, busyAes}), 8'd0);
    rst_n = 1'b1;
    tick();

    // SHA single ack, granted on the first DRIVE cycle.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("single pending", 8'(pendSha), 8'd1);
    checkOutput("single busy idle", 8'(busySha), 8'd0);
    tick();
    checkOutput("single sense busy", 8'(busySha), 8'd1);
    checkOutput("single sense released", 8'(shaIf.ack_valid_n_drv), 8'd1);
    tick();
    checkOutput("single drive valid_n", 8'(shaIf.ack_valid_n_drv), 8'd0);
    checkOutput("single drive id", 8'(shaIf.ack_id_drv), 8'(SRC_SHA));
    checkOutput("single drive req", 8'(shaIf.req), 8'd1);
    grantNow(SRC_SHA);
    checkOutput("single release valid_n", 8'(shaIf.ack_valid_n_drv), 8'd1);
    checkOutput("single release id", 8'(shaIf.ack_id_drv), 8'(ACK_ID_IDLE));
    checkOutput("single release req", 8'(shaIf.req), 8'd0);
    checkOutput("single pending drained", 8'(pendSha), 8'd0);
    tick();
    checkOutput("single busy low", 8'(busySha), 8'd0);
    checkOutput("single no overflow", 8'(ovfSha), 8'd0);

    // Back-to-back acks with saturation.
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("b2b pending saturated", 8'(pendSha), 8'd3);
    checkOutput("b2b overflow", 8'(ovfSha), 8'd1);
    for (int k = 0; k < 3; k++) begin
      waitAndGrant(SRC_SHA, 10);
      checkOutput("b2b pending after grant", 8'(pendSha), 8'(2 - k));
      checkOutput("b2b released gap", 8'(shaIf.ack_valid_n_drv), 8'd1);
    end
    tick(); tick();
    checkOutput("b2b idle", 8'(busySha), 8'd0);
    checkOutput("b2b no timeout", 8'(toSha), 8'd0);

    // Collision: SHA and AES start together, bus resolves to 00.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(); tick();
    checkOutput("collide bus valid", 8'(busValidN), 8'd0);
    checkOutput("collide bus id", 8'(busId), 8'd0);
    tick();
    checkOutput("collide sha backoff", 8'(shaIf.ack_valid_n_drv), 8'd1);
    checkOutput("collide aes backoff", 8'(aesIf.ack_valid_n_drv), 8'd1);
    checkOutput("collide sha req", 8'(shaIf.req), 8'd0);
    tick(); tick(); tick(); tick();
    checkOutput("collide sha still backing off", 8'(shaIf.ack_valid_n_drv), 8'd1);
    tick();
    checkOutput("collide sha redrive", 8'(shaIf.ack_valid_n_drv), 8'd0);
    checkOutput("collide sha alone on bus", 8'(busId), 8'(SRC_SHA));
    tick(); tick();
    checkOutput("collide aes sensing", 8'(aesIf.ack_valid_n_drv), 8'd1);
    checkOutput("collide aes busy", 8'(busyAes), 8'd1);
    grantNow(SRC_SHA);
    checkOutput("collide aes waits for release", 8'(aesIf.ack_valid_n_drv), 8'd1);
    waitAndGrant(SRC_AES, 8);
    checkOutput("collide aes pending", 8'(pendAes), 8'd0);
    tick(); tick();

    // Timeout: no grant for the whole DRIVE window, then a successful retry.
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("timeout drive start", 8'(shaIf.ack_valid_n_drv), 8'd0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("timeout still driving at 15", 8'(shaIf.ack_valid_n_drv), 8'd0);
    checkOutput("timeout flag not yet", 8'(toSha), 8'd0);
    tick();
    checkOutput("timeout released at 16", 8'(shaIf.ack_valid_n_drv), 8'd1);
    checkOutput("timeout flag", 8'(toSha), 8'd1);
    checkOutput("timeout pending kept", 8'(pendSha), 8'd1);
    waitAndGrant(SRC_SHA, 12);
    checkOutput("timeout retry drained", 8'(pendSha), 8'd0);
    tick(); tick();

    // Simultaneous done_pulse and grant at pending=1.
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitDrive(SRC_SHA, 6, found);
    checkOutput("simul drive seen", 8'(found), 8'd1);
    doneSha = 1'b1;
    expQ.push_back(SRC_SHA);
    grantNow(SRC_SHA);
    doneSha = 1'b0;
    checkOutput("simul pending unchanged", 8'(pendSha), 8'd1);
    checkOutput("simul release", 8'(shaIf.ack_valid_n_drv), 8'd1);
    waitAndGrant(SRC_SHA, 8);
    checkOutput("simul pending drained", 8'(pendSha), 8'd0);
    tick(); tick();

    // Asynchronous reset in the middle of a DRIVE phase.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDrive(SRC_SHA, 6, found);
    checkOutput("reset-mid drive seen", 8'(found), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset-mid valid_n", 8'(shaIf.ack_valid_n_drv), 8'd1);
    checkOutput("reset-mid id", 8'(shaIf.ack_id_drv), 8'(ACK_ID_IDLE));
    checkOutput("reset-mid req", 8'(shaIf.req), 8'd0);
    checkOutput("reset-mid pending", 8'(pendSha), 8'd0);
    checkOutput("reset-mid sticky flags", 8'({ovfSha, toSha}), 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("scoreboard drained", 8'(expQ.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
